// File: rtl/alg_amba_vip_base_delayline_ctrl.sv
// alg_amba_vip_base_delayline_ctrl
//
// Control-side initiator for one AMBA VIP delay-line channel. Opens a
// window of nb_req beats with a delay of len_value, waits for the channel
// to report full, waits for it to report drained, then reloads. Bypass
// mode holds the channel transparent for as long as enable stays high.
//
// Optional feature macro: ALG_AMBA_VIP_DELAYLINE_CTRL_RAND_EN
//   defined   : random-delay mode (mode 1) and its 16-bit LFSR are built
//   undefined : no LFSR; mode 1 uses cfg_delay exactly like mode 0
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   enable         run windows while high; a running window always completes
//   mode[1:0]      0 fixed, 1 random, 2 bypass, 3 treated as fixed
//   cfg_delay      fixed delay value
//   cfg_delay_max  upper bound for the random delay
//   cfg_burst      beats per window (0 encodes 2^FIFO_LOG2)
//   bypass         to channel, high while in bypass
//   nb_req         to channel, beats for the current window
//   len_valid      to channel, one-cycle load strobe
//   len_value      to channel, delay for the current window
//   full_req       from channel, fill complete pulse
//   need_len       from channel, drained / wants a new length pulse
//   empty_req      from channel, drained pulse
//   busy           controller not idle
//   windows_done   completed window count, wraps
//   proto_err      sticky protocol violation flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for enable; mode and cfg_* are captured on exit
// LOAD  | one cycle; the registered outputs present the new window
// FILL  | waiting for full_req from the channel
// DRAIN | waiting for empty_req or need_len to close the window
// BYP   | channel bypassed until enable drops

module alg_amba_vip_base_delayline_ctrl #(
    parameter int          FIFO_LOG2  = 6,
    parameter int          SHIFT_LOG2 = 6,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [15:0]          cfg_delay,
    input  logic [15:0]          cfg_delay_max,
    input  logic [FIFO_LOG2-1:0] cfg_burst,
    output logic                 bypass,
    output logic [FIFO_LOG2-1:0] nb_req,
    output logic                 len_valid,
    output logic [15:0]          len_value,
    input  logic                 full_req,
    input  logic                 need_len,
    input  logic                 empty_req,
    output logic                 busy,
    output logic [15:0]          windows_done,
    output logic                 proto_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FILL  = 3'd2,
        S_DRAIN = 3'd3,
        S_BYP   = 3'd4
    } state_t;

    localparam logic [15:0] DLY_MAX = 16'((32'd1 << SHIFT_LOG2) - 32'd1);

    state_t               state;
    state_t               state_nxt;
    logic                 drain_pulse;
    logic                 exit_idle;
    logic [15:0]          cfg_delay_q;
    logic [FIFO_LOG2-1:0] burst_q;
    logic [15:0]          dly_fixed;
    logic [15:0]          dly_sel;

    // output-process results, registered below
    logic                 bypass_d;
    logic                 busy_d;
    logic                 len_valid_d;
    logic                 load_now;
    logic                 window_end;
    logic                 err_set;

    assign drain_pulse = need_len | empty_req;
    assign exit_idle   = (state == S_IDLE) && (state_nxt != S_IDLE);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = (mode == 2'd2) ? S_BYP : S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_FILL;
            end
            S_FILL: begin
                // a drain pulse here, with or without full_req, closes the window
                if (drain_pulse) begin
                    state_nxt = enable ? S_LOAD : S_IDLE;
                end else if (full_req) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_pulse) begin
                    state_nxt = enable ? S_LOAD : S_IDLE;
                end
            end
            S_BYP: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        bypass_d    = 1'b0;
        busy_d      = 1'b0;
        len_valid_d = 1'b0;
        load_now    = 1'b0;
        window_end  = 1'b0;
        err_set     = 1'b0;
        // bypass and busy follow the next state so they change together
        // with the state register rather than a cycle later
        bypass_d = (state_nxt == S_BYP);
        busy_d   = (state_nxt != S_IDLE);
        case (state)
            S_LOAD: begin
                len_valid_d = 1'b1;
                load_now    = 1'b1;
            end
            S_FILL: begin
                window_end = drain_pulse;
                err_set    = drain_pulse && !full_req;
            end
            S_DRAIN: begin
                window_end = drain_pulse;
                err_set    = full_req;
            end
            default: begin
                len_valid_d = 1'b0;
            end
        endcase
    end

    // ---------------- configuration capture ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_delay_q <= '0;
            burst_q     <= '0;
        end else begin
            if (exit_idle) begin
                cfg_delay_q <= cfg_delay;
            end
            if (exit_idle || (state_nxt == S_LOAD)) begin
                burst_q <= cfg_burst;
            end
        end
    end

    assign dly_fixed = (cfg_delay_q > DLY_MAX) ? DLY_MAX : cfg_delay_q;

`ifdef ALG_AMBA_VIP_DELAYLINE_CTRL_RAND_EN
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [1:0]  mode_q;
    logic [15:0] cfg_delay_max_q;
    logic [15:0] lfsr;
    logic [15:0] lfsr_masked;
    logic [15:0] dly_rand;
    logic        rand_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q          <= '0;
            cfg_delay_max_q <= '0;
        end else if (exit_idle) begin
            mode_q          <= mode;
            cfg_delay_max_q <= cfg_delay_max;
        end
    end

    assign rand_mode = (mode_q == 2'd1);

    // Fibonacci, taps 16,14,13,11; steps once per random-mode LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED_EFF;
        end else if (load_now && rand_mode) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // masked value never exceeds DLY_MAX, so the min also stays in range
    assign lfsr_masked = lfsr & DLY_MAX;
    assign dly_rand    = (lfsr_masked > cfg_delay_max_q) ? cfg_delay_max_q : lfsr_masked;
    assign dly_sel     = rand_mode ? dly_rand : dly_fixed;
`else
    logic unused_rand_cfg;

    assign unused_rand_cfg = ^{cfg_delay_max, LFSR_SEED};
    assign dly_sel         = dly_fixed;
`endif

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass       <= 1'b0;
            busy         <= 1'b0;
            len_valid    <= 1'b0;
            nb_req       <= '0;
            len_value    <= '0;
            windows_done <= '0;
            proto_err    <= 1'b0;
        end else begin
            bypass    <= bypass_d;
            busy      <= busy_d;
            len_valid <= len_valid_d;
            if (load_now) begin
                nb_req    <= burst_q;
                len_value <= dly_sel;
            end
            if (window_end) begin
                windows_done <= windows_done + 16'd1;
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alg_amba_vip_base_delayline_ctrl.sv
module tb_alg_amba_vip_base_delayline_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_delay_max;
    logic [5:0]  cfg_burst;
    logic        bypass;
    logic [5:0]  nb_req;
    logic        len_valid;
    logic [15:0] len_value;
    logic        full_req;
    logic        need_len;
    logic        empty_req;
    logic        busy;
    logic [15:0] windows_done;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    alg_amba_vip_base_delayline_ctrl #(
        .FIFO_LOG2 (6),
        .SHIFT_LOG2(6),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .cfg_delay    (cfg_delay),
        .cfg_delay_max(cfg_delay_max),
        .cfg_burst    (cfg_burst),
        .bypass       (bypass),
        .nb_req       (nb_req),
        .len_valid    (len_valid),
        .len_value    (len_value),
        .full_req     (full_req),
        .need_len     (need_len),
        .empty_req    (empty_req),
        .busy         (busy),
        .windows_done (windows_done),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  mode;
        logic        full;
        logic        need;
        logic        empty;
        logic [15:0] dly;
        int          hold;
        logic        lv;
        logic [15:0] nb;
        logic [15:0] lval;
        logic        busy;
        logic        byp;
        logic [15:0] wd;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic f, input logic n, input logic em,
                                input logic [15:0] d, input int h,
                                input logic lv, input logic [15:0] nb,
                                input logic [15:0] lval, input logic bs,
                                input logic by, input logic [15:0] wd,
                                input logic er);
        vec_t v;
        v.rst = r;  v.en = e;  v.mode = m;  v.full = f;  v.need = n;
        v.empty = em;  v.dly = d;  v.hold = h;  v.lv = lv;  v.nb = nb;
        v.lval = lval;  v.busy = bs;  v.byp = by;  v.wd = wd;  v.err = er;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int row,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic pulse_close();
        full_req  = 1'b1;
        empty_req = 1'b1;
        step();
        full_req  = 1'b0;
        empty_req = 1'b0;
    endtask

    // runs n back-to-back random windows from reset and compares each length
    task automatic random_run(input logic [15:0] dmax, input int n, input int tag);
        logic [15:0] model;
        logic [15:0] m;
        logic [15:0] exp;
        rst = 1'b1;  enable = 1'b0;
        step();
        rst = 1'b0;  mode = 2'd1;  cfg_delay = 16'd50;  cfg_delay_max = dmax;
        enable = 1'b1;
        model = 16'hACE1;
        step();
        for (int w = 0; w < n; w++) begin
            step();
            m   = model & 16'h003F;
            exp = (m > dmax) ? dmax : m;
            check("rand_len_valid", tag + w, {15'd0, len_valid}, 16'd1);
            check("rand_len_value", tag + w, len_value, exp);
            if (len_value > dmax) begin
                errors++;
                $display("FAIL rand_bound (row %0d): got %0d, limit %0d", tag + w, len_value, dmax);
            end
            checks++;
            model = lfsr_step(model);
            pulse_close();
        end
        enable = 1'b0;
        step();
        pulse_close();
        check("rand_windows", tag, windows_done, 16'(n + 1));
    endtask

    initial begin
        rst = 1'b1;  enable = 1'b0;  mode = 2'd0;
        cfg_delay = 16'd10;  cfg_delay_max = 16'd5;  cfg_burst = 6'd4;
        full_req = 1'b0;  need_len = 1'b0;  empty_req = 1'b0;

        //            rst en mode  f  n  e  dly  hold | lv nb lval busy byp wd err
        tbl.push_back(mk(1, 0, 2'd0, 0, 0, 0, 10,  2,   0, 0, 0,  0, 0, 0, 0)); // 0 reset
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 10,  1,   0, 0, 0,  1, 0, 0, 0)); // 1 LOAD
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 10,  1,   1, 4, 10, 1, 0, 0, 0)); // 2 len_valid
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 10,  4,   0, 4, 10, 1, 0, 0, 0)); // 3 FILL wait
        tbl.push_back(mk(0, 1, 2'd0, 1, 0, 0, 10,  1,   0, 4, 10, 1, 0, 0, 0)); // 4 full
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 10, 19,   0, 4, 10, 1, 0, 0, 0)); // 5 DRAIN wait
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 1, 10,  1,   0, 4, 10, 1, 0, 1, 0)); // 6 empty
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 10,  1,   1, 4, 10, 1, 0, 1, 0)); // 7 reload
        tbl.push_back(mk(0, 1, 2'd0, 1, 0, 1, 10,  1,   0, 4, 10, 1, 0, 2, 0)); // 8 full+empty
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 10,  1,   1, 4, 10, 1, 0, 2, 0)); // 9 reload
        tbl.push_back(mk(0, 0, 2'd0, 1, 0, 0, 10,  1,   0, 4, 10, 1, 0, 2, 0)); // 10 full, en low
        tbl.push_back(mk(0, 0, 2'd0, 0, 1, 0, 200, 1,   0, 4, 10, 0, 0, 3, 0)); // 11 need_len -> IDLE
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 200, 1,   0, 4, 10, 1, 0, 3, 0)); // 12 LOAD
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 200, 1,   1, 4, 63, 1, 0, 3, 0)); // 13 saturation
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 1, 200, 1,   0, 4, 63, 1, 0, 4, 1)); // 14 empty alone in FILL
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 200, 1,   1, 4, 63, 1, 0, 4, 1)); // 15 reload
        tbl.push_back(mk(0, 1, 2'd0, 1, 0, 0, 200, 1,   0, 4, 63, 1, 0, 4, 1)); // 16 full
        tbl.push_back(mk(0, 1, 2'd0, 1, 0, 0, 200, 1,   0, 4, 63, 1, 0, 4, 1)); // 17 full in DRAIN
        tbl.push_back(mk(0, 0, 2'd0, 0, 0, 1, 200, 3,   0, 4, 63, 0, 0, 5, 1)); // 18 -> IDLE, sticky err
        tbl.push_back(mk(1, 0, 2'd0, 0, 0, 0, 7,   1,   0, 0, 0,  0, 0, 0, 0)); // 19 reset
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 7,   1,   0, 0, 0,  1, 0, 0, 0)); // 20 LOAD
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 7,   1,   1, 4, 7,  1, 0, 0, 0)); // 21 len_valid
        tbl.push_back(mk(0, 1, 2'd0, 1, 0, 0, 7,   1,   0, 4, 7,  1, 0, 0, 0)); // 22 full
        tbl.push_back(mk(0, 1, 2'd0, 1, 0, 0, 7,   1,   0, 4, 7,  1, 0, 0, 1)); // 23 full in DRAIN
        tbl.push_back(mk(0, 1, 2'd0, 0, 1, 0, 7,   1,   0, 4, 7,  1, 0, 1, 1)); // 24 need_len
        tbl.push_back(mk(0, 1, 2'd0, 0, 0, 0, 7,   1,   1, 4, 7,  1, 0, 1, 1)); // 25 reload
        tbl.push_back(mk(0, 1, 2'd0, 1, 0, 0, 7,   1,   0, 4, 7,  1, 0, 1, 1)); // 26 full -> DRAIN
        tbl.push_back(mk(1, 1, 2'd0, 0, 0, 1, 7,   1,   0, 0, 0,  0, 0, 0, 0)); // 27 rst in DRAIN
        tbl.push_back(mk(0, 1, 2'd2, 0, 0, 0, 7,   1,   0, 0, 0,  1, 1, 0, 0)); // 28 bypass
        tbl.push_back(mk(0, 1, 2'd2, 1, 1, 1, 7,   1,   0, 0, 0,  1, 1, 0, 0)); // 29 pulses ignored
        tbl.push_back(mk(0, 1, 2'd2, 0, 0, 0, 7,  50,   0, 0, 0,  1, 1, 0, 0)); // 30 50 cycles
        tbl.push_back(mk(0, 0, 2'd2, 0, 0, 0, 7,   1,   0, 0, 0,  0, 0, 0, 0)); // 31 drop enable
        tbl.push_back(mk(0, 1, 2'd3, 0, 0, 0, 9,   1,   0, 0, 0,  1, 0, 0, 0)); // 32 mode 3 LOAD
        tbl.push_back(mk(0, 1, 2'd3, 0, 0, 0, 9,   1,   1, 4, 9,  1, 0, 0, 0)); // 33 fixed delay
        tbl.push_back(mk(0, 0, 2'd3, 1, 1, 0, 9,   1,   0, 4, 9,  0, 0, 1, 0)); // 34 close, IDLE

        for (int r = 0; r < tbl.size(); r++) begin
            rst       = tbl[r].rst;
            enable    = tbl[r].en;
            mode      = tbl[r].mode;
            full_req  = tbl[r].full;
            need_len  = tbl[r].need;
            empty_req = tbl[r].empty;
            cfg_delay = tbl[r].dly;
            for (int h = 0; h < tbl[r].hold; h++) begin
                step();
                // pulses last a single cycle even on multi-cycle rows
                full_req  = 1'b0;
                need_len  = 1'b0;
                empty_req = 1'b0;
                check("len_valid",    r, {15'd0, len_valid}, {15'd0, tbl[r].lv});
                check("nb_req",       r, {10'd0, nb_req},    tbl[r].nb);
                check("len_value",    r, len_value,          tbl[r].lval);
                check("busy",         r, {15'd0, busy},      {15'd0, tbl[r].busy});
                check("bypass",       r, {15'd0, bypass},    {15'd0, tbl[r].byp});
                check("windows_done", r, windows_done,       tbl[r].wd);
                check("proto_err",    r, {15'd0, proto_err}, {15'd0, tbl[r].err});
            end
        end

`ifdef ALG_AMBA_VIP_DELAYLINE_CTRL_RAND_EN
        random_run(16'd5, 100, 1000);
        random_run(16'd40, 20, 2000);
`else
        // without the random feature, mode 1 uses cfg_delay
        rst = 1'b1;  enable = 1'b0;
        step();
        rst = 1'b0;  mode = 2'd1;  cfg_delay = 16'd12;  cfg_delay_max = 16'd5;
        enable = 1'b1;
        step();
        step();
        check("mode1_len_valid", 3000, {15'd0, len_valid}, 16'd1);
        check("mode1_len_value", 3000, len_value, 16'd12);
        check("mode1_nb_req",    3000, {10'd0, nb_req}, 16'd4);
        enable = 1'b0;
        pulse_close();
        check("mode1_windows",   3000, windows_done, 16'd1);
        check("mode1_busy",      3000, {15'd0, busy}, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alg_amba_vip_base_delayline_ctrl.md
# alg_amba_vip_base_delayline_ctrl

Control-side initiator for one AMBA VIP delay-line channel: drives the channel's `bypass`, `nb_req`, `len_valid` and `len_value` inputs. It consumes the channel's `full_req`, `need_len` and `empty_req` status pulses. Sequencing is window-by-window: open a window of N beats with delay D, wait for fill, wait for drain, then reload. One instance sits beside each delay-line channel (AW/W/B/AR/R) in the VIP testbench, configured by the sequence layer through static cfg ports.

## Interface
- `FIFO_LOG2`, 6, width of `nb_req`/`cfg_burst`; must match the channel's FIFO_LOG2
- `SHIFT_LOG2`, 6, shift depth log2 of the channel; sets the delay saturation limit
- `LFSR_SEED`, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `enable`  in  1  run windows while high; on deassertion, finish the current window, then idle
- `mode`  in  2  0 fixed delay, 1 random delay, 2 bypass, 3 reserved (treated as 0); sampled only in IDLE
- `cfg_delay`  in  16  fixed delay value
- `cfg_delay_max`  in  16  upper bound for random delay
- `cfg_burst`  in  FIFO_LOG2  beats per window; 0 = 2^FIFO_LOG2
- `bypass`  out  1  to channel
- `nb_req`  out  FIFO_LOG2  to channel
- `len_valid`  out  1  to channel, single-cycle pulse
- `len_value`  out  16  to channel
- `full_req`  in  1  from channel, pulse
- `need_len`  in  1  from channel, pulse
- `empty_req`  in  1  from channel, pulse
- `busy`  out  1  state != IDLE
- `windows_done`  out  16  completed windows, wraps at 16'hFFFF -> 0
- `proto_err`  out  1  sticky; cleared only by `rst`

## Operation
- States: IDLE, LOAD, FILL, DRAIN, BYP.
- **IDLE**
  - `enable` && mode 2 -> BYP.
  - `enable` && mode != 2 -> LOAD.
  - Latches `mode` and `cfg_burst` on exit.
- **LOAD** (exactly one cycle)
  - `len_valid` = 1.
  - `nb_req` = latched burst.
  - `len_value` = computed delay.
  - Next state is FILL.
- **Delay computation**
  - Fixed: `cfg_delay`.
  - Random: `lfsr & (2^SHIFT_LOG2-1)`, then min with `cfg_delay_max`.
  - Both results saturate to 2^SHIFT_LOG2-1; upper bits of `len_value` are 0.
- **FILL**
  - Waits for `full_req`, then goes to DRAIN.
  - If `full_req` and `need_len`/`empty_req` arrive in the same cycle, treat it as fill+drain: go to LOAD if `enable`, else IDLE, and increment `windows_done`.
  - `empty_req` or `need_len` alone in FILL sets `proto_err`; the state then proceeds as if drained.
- **DRAIN**
  - Waits for `empty_req` or `need_len` (OR-ed), then increments `windows_done`.
  - Next state is LOAD if `enable`, else IDLE.
  - `full_req` in DRAIN sets `proto_err` and is otherwise ignored.
- **BYP**
  - `bypass` = 1; no `len_valid` is issued; status pulses are ignored.
  - `enable` low -> IDLE, clearing `bypass` the same cycle as the state change.
- **LFSR**
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances exactly once per LOAD in random mode; it is frozen otherwise.
- `mode` and `cfg_*` changes outside IDLE have no effect until the next IDLE exit. `cfg_burst` is re-latched at every LOAD.

## Timing
- Reset values:
  - State IDLE.
  - `bypass` 0, `nb_req` 0, `len_valid` 0, `len_value` 0.
  - `busy` 0, `windows_done` 0, `proto_err` 0.
  - LFSR = `LFSR_SEED` (or 1 if the seed is 0).
- All outputs are registered.
- `enable` rising in IDLE: `len_valid` high exactly 2 cycles later (one IDLE->LOAD transition cycle, then the registered output).
- Back-to-back windows: drain pulse at cycle t -> `len_valid` at t+2.
- `nb_req`/`len_value` are stable from the `len_valid` cycle until the next `len_valid`.
- `rst` mid-window: all state returns to reset values on the next edge. A pending drain is not counted.

## Configuration
- `ALG_AMBA_VIP_DELAYLINE_CTRL_RAND_EN` defined: random mode and the LFSR are present.
- Undefined: no LFSR logic; mode 1 behaves as mode 0 (`cfg_delay` used).

## Test plan
- Fixed mode, `cfg_burst`=4, `cfg_delay`=10, `enable` held. Stimulus: `full_req` 5 cycles after `len_valid`, `empty_req` 20 cycles later. Required response: `len_valid` with `nb_req`=4, `len_value`=10, then the next `len_valid` 2 cycles after `empty_req`, and `windows_done`=1.
- Saturation: `cfg_delay`=200 with SHIFT_LOG2=6 -> `len_value`=63.
- Random mode, seed 16'hACE1, `cfg_delay_max`=5. Over 100 windows: every `len_value` is <= 5, and the sequence matches the golden LFSR model.
- Simultaneous pulses: `full_req` and `empty_req` in the same FILL cycle -> no `proto_err`, `windows_done` increments, next `len_valid` 2 cycles later.
- Protocol errors: `empty_req` alone in FILL -> `proto_err`=1 and stays 1 until `rst`. `full_req` in DRAIN also sets it.
- Bypass mode 2, `enable` high: `bypass`=1 and no `len_valid` for 50 cycles. Dropping `enable` gives `bypass`=0 next cycle. `rst` asserted during DRAIN clears all outputs, including `windows_done`.
